// File: rtl/bin_to_bcd.sv
// Registered binary-to-BCD converter: combinational double-dabble core, one output register
// stage, saturating to all-nines with an overflow flag when the value needs more digits.
module bin_to_bcd #(
   parameter int unsigned BIN_W  = 14,
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [BIN_W-1:0]      bin,
   input  logic                  in_valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf,
   output logic                  out_valid
);

   // Every 3 input bits add less than one decimal digit (8 < 10), so this always holds the result.
   localparam int unsigned ConvDigits = (BIN_W + 2) / 3;

   function automatic int unsigned pow10_minus1(input int unsigned n);
      int unsigned p;
      p = 1;
      for (int unsigned k = 0; k < n; k++) p = p * 10;
      return p - 1;
   endfunction

   localparam int unsigned MaxVal = pow10_minus1(DIGITS);

   logic [4*ConvDigits-1:0] scratch;
   logic [BIN_W-1:0]        bin_sh;
   logic [4*DIGITS-1:0]     bcd_d, bcd_q;
   logic                    ovf_d, ovf_q;
   logic                    valid_q;

   always_comb begin
      scratch = '0;
      bin_sh  = bin;
      for (int unsigned i = 0; i < BIN_W; i++) begin
         for (int unsigned d = 0; d < ConvDigits; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) scratch[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
         end
         scratch = {scratch[4*ConvDigits-2:0], bin_sh[BIN_W-1]};
         bin_sh  = bin_sh << 1;
      end
   end

   always_comb begin
      ovf_d = (32'(bin) > MaxVal);
      bcd_d = ovf_d ? {DIGITS{4'h9}} : scratch[4*DIGITS-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            bcd_q <= bcd_d;
            ovf_q <= ovf_d;
         end
      end
   end

   assign bcd       = bcd_q;
   assign ovf       = ovf_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed, boundary, hold, reset and exhaustive/random
// scenarios compared against an arithmetic decimal-digit reference model.
module tb_bin_to_bcd;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [13:0] bin;
   logic        in_valid;
   logic [15:0] bcd;
   logic        ovf;
   logic        out_valid;

   int tests = 0;
   int fails = 0;

   bin_to_bcd #(.BIN_W(14), .DIGITS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bin       (bin),
      .in_valid  (in_valid),
      .bcd       (bcd),
      .ovf       (ovf),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   // Expected {out_valid, ovf, bcd} from plain decimal arithmetic.
   function automatic logic [17:0] model(input int v, input logic vld);
      logic [15:0] b;
      logic        o;
      o = (v > 9999);
      if (o) b = 16'h9999;
      else   b = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
      return {vld, o, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [17:0] exp_v;
      rst_n = 1'b0; in_valid = 1'b1; bin = 14'd1234;
      exp_v = {1'b0, 1'b0, 16'h0000};
      for (int c = 0; c < 2; c++) begin
         tick();
         tests++;
         if ({out_valid, ovf, bcd} !== exp_v) begin
            fails++;
            $display("FAIL reset cycle %0d: got %h, expected %h", c, {out_valid, ovf, bcd}, exp_v);
         end
      end
      rst_n = 1'b1; in_valid = 1'b0;
   endtask

   task automatic test_directed();
      int vals[4] = '{4567, 78, 67, 4227};
      logic [17:0] exp_v;
      foreach (vals[k]) begin
         bin = 14'(vals[k]); in_valid = 1'b1;
         tick();
         exp_v = model(vals[k], 1'b1);
         tests++;
         if ({out_valid, ovf, bcd} !== exp_v) begin
            fails++;
            $display("FAIL directed bin=%0d: got %h, expected %h", vals[k], {out_valid, ovf, bcd}, exp_v);
         end
      end
   endtask

   task automatic test_bounds();
      int vals[6] = '{0, 9999, 10000, 16383, 9998, 10001};
      logic [17:0] exp_v;
      foreach (vals[k]) begin
         bin = 14'(vals[k]); in_valid = 1'b1;
         tick();
         exp_v = model(vals[k], 1'b1);
         tests++;
         if ({out_valid, ovf, bcd} !== exp_v) begin
            fails++;
            $display("FAIL bounds bin=%0d: got %h, expected %h", vals[k], {out_valid, ovf, bcd}, exp_v);
         end
      end
   endtask

   task automatic test_hold();
      bin = 14'd321; in_valid = 1'b1;
      tick();
      tests++;
      if ({out_valid, ovf, bcd} !== {1'b1, 1'b0, 16'h0321}) begin
         fails++;
         $display("FAIL hold_load: got %h, expected %h", {out_valid, ovf, bcd}, {2'b10, 16'h0321});
      end
      bin = 14'd555; in_valid = 1'b0;
      tick();
      tests++;
      if ({out_valid, ovf, bcd} !== {1'b0, 1'b0, 16'h0321}) begin
         fails++;
         $display("FAIL hold_idle: got %h, expected %h", {out_valid, ovf, bcd}, {2'b00, 16'h0321});
      end
   endtask

   task automatic test_reset_mid();
      int vals[5] = '{100, 12000, 300, 400, 9081};
      logic [17:0] exp_v;
      foreach (vals[k]) begin
         bin = 14'(vals[k]); in_valid = 1'b1;
         rst_n = (k != 2);
         tick();
         exp_v = (k == 2) ? 18'h0 : model(vals[k], 1'b1);
         tests++;
         if ({out_valid, ovf, bcd} !== exp_v) begin
            fails++;
            $display("FAIL reset_mid step %0d: got %h, expected %h", k, {out_valid, ovf, bcd}, exp_v);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_exhaustive();
      logic [17:0] exp_v;
      for (int v = 0; v < 16384; v++) begin
         bin = 14'(v); in_valid = 1'b1;
         tick();
         exp_v = model(v, 1'b1);
         tests++;
         if ({out_valid, ovf, bcd} !== exp_v) begin
            fails++;
            $display("FAIL exhaustive bin=%0d: got %h, expected %h", v, {out_valid, ovf, bcd}, exp_v);
         end
      end
   endtask

   task automatic test_random();
      int          last_v;
      logic        vld;
      logic [17:0] exp_v;
      // Start from a known accepted value so holds have a defined expectation.
      last_v = 5;
      bin = 14'(last_v); in_valid = 1'b1;
      tick();
      for (int n = 0; n < 2000; n++) begin
         vld = 1'($urandom_range(0, 1));
         bin = 14'($urandom_range(0, 16383));
         in_valid = vld;
         if (vld) last_v = int'(bin);
         tick();
         exp_v = model(last_v, vld);
         tests++;
         if ({out_valid, ovf, bcd} !== exp_v) begin
            fails++;
            $display("FAIL random step %0d: got %h, expected %h", n, {out_valid, ovf, bcd}, exp_v);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; bin = '0;
      test_reset();
      test_directed();
      test_bounds();
      test_hold();
      test_reset_mid();
      test_exhaustive();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
